// File: rtl/mfcc_pkg.sv
// Shared state encoding and Q1.15 arithmetic helpers for the MFCC front end.
package mfcc_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_EMIT, ST_HOP} state_t;

  localparam int Q15_W = 16;
  localparam logic signed [Q15_W-1:0] ONE_Q15 = 16'sh7FFF;
  localparam logic signed [Q15_W-1:0] RND_Q15 = 16'sh4000;

  function automatic logic signed [Q15_W-1:0] sat_q15(input logic signed [39:0] v);
    if (v > 40'sd32767)  return ONE_Q15;
    if (v < -40'sd32768) return 16'sh8000;
    return v[Q15_W-1:0];
  endfunction

endpackage

// File: rtl/mfcc_framer_if.sv
// PCM input stream, window coefficient port and framed output stream of the framer.
interface mfcc_framer_if #(
  parameter int FRAME_LEN = 256,
  parameter int DATA_W    = 16
);
  localparam int AW = $clog2(FRAME_LEN);

  logic signed [DATA_W-1:0] pcm_in;
  logic                     pcm_valid;
  logic                     pcm_ready;
  logic                     coef_wr_en;
  logic [AW-1:0]            coef_wr_addr;
  logic signed [DATA_W-1:0] coef_wr_data;
  logic                     coef_wr_err;
  logic signed [DATA_W-1:0] framed_out;
  logic                     framed_valid;
  logic                     frame_start;
  logic                     frame_last;
  logic [15:0]              frame_cnt;

  modport master (
    output pcm_in, pcm_valid, coef_wr_en, coef_wr_addr, coef_wr_data,
    input  pcm_ready, coef_wr_err, framed_out, framed_valid, frame_start, frame_last, frame_cnt
  );

  modport slave (
    input  pcm_in, pcm_valid, coef_wr_en, coef_wr_addr, coef_wr_data,
    output pcm_ready, coef_wr_err, framed_out, framed_valid, frame_start, frame_last, frame_cnt
  );
endinterface

// File: rtl/mfcc_frame_buf.sv
// Simple dual-port RAM with registered read; no reset on the array.
module mfcc_frame_buf #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/mfcc_framer.sv
// Overlapping-frame windowing: circular sample buffer, frame FSM and a
// two-stage read / multiply-round pipeline feeding the DFT stage.
module mfcc_framer
  import mfcc_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128,
  parameter int DATA_W    = 16
) (
  input logic          clk,
  input logic          rst,
  input logic          enable,
  mfcc_framer_if.slave bus
);
  localparam int AW     = $clog2(FRAME_LEN);
  localparam int PW     = 2 * DATA_W;
  localparam int STAGES = 2;
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);
  localparam logic [AW-1:0] HOP_LAST = AW'(HOP - 1);

  state_t state, state_nxt;
  logic [AW-1:0] wr_ptr, cnt, rd_idx;
  logic accept, rd_en, coef_we;
  logic [DATA_W-1:0] smp_q, coef_raw_q;
  logic signed [DATA_W-1:0] smp_s, coef_s;
  logic signed [PW-1:0] prod;
  logic signed [39:0] rnd;
  logic [STAGES:1] vld_pipe;
  logic start_q, last_q;

  assign accept  = bus.pcm_valid & bus.pcm_ready;
  assign coef_we = bus.coef_wr_en && (state != ST_EMIT);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (enable) state_nxt = ST_FILL;
      ST_FILL: if (!enable) state_nxt = ST_IDLE;
               else if (accept && cnt == LAST_IDX) state_nxt = ST_EMIT;
      ST_EMIT: if (rd_idx == LAST_IDX) state_nxt = enable ? ST_HOP : ST_IDLE;
      ST_HOP:  if (!enable) state_nxt = ST_IDLE;
               else if (accept && cnt == HOP_LAST) state_nxt = ST_EMIT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.pcm_ready = 1'b0;
    rd_en         = 1'b0;
    case (state)
      ST_FILL, ST_HOP: bus.pcm_ready = 1'b1;
      ST_EMIT:         rd_en = 1'b1;
      default: ;
    endcase
  end

  // wr_ptr is frozen during EMIT, so it doubles as the read base (oldest sample)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      cnt    <= '0;
      rd_idx <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (accept) cnt <= cnt + AW'(1);
      else if (state == ST_IDLE || state == ST_EMIT) cnt <= '0;
      if (rd_en) rd_idx <= rd_idx + AW'(1);
    end
  end

  mfcc_frame_buf #(.DEPTH(FRAME_LEN), .WIDTH(DATA_W)) u_smp_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (bus.pcm_in),
    .rd_addr (wr_ptr + rd_idx),
    .rd_data (smp_q)
  );

  // Coefficients are stored XORed with ONE_Q15 so a zeroed array reads as a rectangular window
  mfcc_frame_buf #(.DEPTH(FRAME_LEN), .WIDTH(DATA_W)) u_coef_buf (
    .clk     (clk),
    .wr_en   (coef_we),
    .wr_addr (bus.coef_wr_addr),
    .wr_data (bus.coef_wr_data ^ ONE_Q15),
    .rd_addr (rd_idx),
    .rd_data (coef_raw_q)
  );

  assign smp_s  = smp_q;
  assign coef_s = coef_raw_q ^ ONE_Q15;
  assign prod   = PW'(smp_s) * PW'(coef_s);
  assign rnd    = (40'(prod) + 40'(RND_Q15)) >>> 15;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe        <= '0;
      start_q         <= 1'b0;
      last_q          <= 1'b0;
      bus.framed_out  <= '0;
      bus.frame_start <= 1'b0;
      bus.frame_last  <= 1'b0;
      bus.frame_cnt   <= '0;
      bus.coef_wr_err <= 1'b0;
    end else begin
      vld_pipe        <= {vld_pipe[STAGES-1:1], rd_en};
      start_q         <= rd_en && rd_idx == '0;
      last_q          <= rd_en && rd_idx == LAST_IDX;
      bus.framed_out  <= vld_pipe[1] ? sat_q15(rnd) : '0;
      bus.frame_start <= start_q;
      bus.frame_last  <= last_q;
      bus.frame_cnt   <= bus.frame_cnt + 16'(last_q);
      bus.coef_wr_err <= bus.coef_wr_en && (state == ST_EMIT);
    end
  end

  assign bus.framed_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_mfcc_framer.sv
// Randomized bench for mfcc_framer against a frame-level scoreboard model.
module tb_mfcc_framer;
  localparam int FL = 8;
  localparam int HP = 4;
  localparam int DW = 16;
  localparam int AW = $clog2(FL);

  logic clk = 1'b0;
  logic rst, enable;

  mfcc_framer_if #(.FRAME_LEN(FL), .DATA_W(DW)) bus ();

  mfcc_framer #(.FRAME_LEN(FL), .HOP(HP), .DATA_W(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int val; bit st; bit ls; } exp_t;
  typedef struct { int a; int d; } cw_t;

  exp_t sched[$];
  int   hist[$];
  int   src_q[$];
  cw_t  cw_q[$];
  int   coef[FL];
  bit   m_on, err_due, acc, quiet;
  int   m_need, m_emit, exp_cnt, cyc;
  int   n_chk, n_fail;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int win(input int x, input int c);
    longint r;
    r = (longint'(x) * longint'(c) + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  // Check this cycle's outputs, then advance the model across the coming edge.
  task automatic tick();
    exp_t e;
    bit ev;
    chk("pcm_ready", bus.pcm_ready, m_on && m_emit == 0);
    ev = sched.size() > 0 && sched[0].cyc == cyc;
    if (ev) begin
      e = sched.pop_front();
      if (e.ls) exp_cnt = (exp_cnt + 1) % 65536;
      chk("framed_out", bus.framed_out, e.val);
      chk("frame_start", bus.frame_start, e.st);
      chk("frame_last", bus.frame_last, e.ls);
    end else begin
      chk("frame_start_idle", bus.frame_start, 0);
      chk("frame_last_idle", bus.frame_last, 0);
      if (quiet) chk("framed_out_idle", bus.framed_out, 0);
    end
    chk("framed_valid", bus.framed_valid, ev);
    chk("frame_cnt", bus.frame_cnt, exp_cnt);
    chk("coef_wr_err", bus.coef_wr_err, err_due);

    acc = 1'b0;
    err_due = 1'b0;
    if (bus.coef_wr_en) begin
      if (m_emit > 0) err_due = !rst;
      else coef[bus.coef_wr_addr] = bus.coef_wr_data;
    end
    if (rst) begin
      m_on = 1'b0; m_emit = 0; m_need = 0; exp_cnt = 0;
      sched.delete();
    end else if (m_emit > 0) begin
      m_emit--;
      if (m_emit == 0) begin m_on = enable; m_need = HP; end
    end else if (!m_on) begin
      if (enable) begin m_on = 1'b1; m_need = FL; end
    end else begin
      if (bus.pcm_valid) begin
        acc = 1'b1;
        hist.push_back(bus.pcm_in);
        if (hist.size() > FL) void'(hist.pop_front());
      end
      if (!enable) m_on = 1'b0;
      else if (acc) begin
        m_need--;
        if (m_need == 0) begin
          for (int k = 0; k < FL; k++)
            sched.push_back('{cyc + 3 + k, win(hist[k], coef[k]), k == 0, k == FL - 1});
          m_emit = FL;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n, input bit en, input int pv_pct, input int cw_pct);
    cw_t c;
    for (int i = 0; i < n; i++) begin
      enable = en;
      if (!bus.pcm_valid || acc) begin
        bus.pcm_valid = ($urandom_range(99) < pv_pct);
        if (bus.pcm_valid)
          bus.pcm_in = (src_q.size() > 0) ? DW'(src_q.pop_front()) : DW'($urandom);
      end
      bus.coef_wr_en = 1'b0;
      if (cw_q.size() > 0) begin
        c = cw_q.pop_front();
        bus.coef_wr_en = 1'b1; bus.coef_wr_addr = AW'(c.a); bus.coef_wr_data = DW'(c.d);
      end else if ($urandom_range(99) < cw_pct) begin
        bus.coef_wr_en = 1'b1; bus.coef_wr_addr = AW'($urandom_range(FL - 1));
        bus.coef_wr_data = DW'($urandom);
      end
      tick();
    end
    bus.coef_wr_en = 1'b0;
  endtask

  task automatic wait_emit(input int lim);
    for (int i = 0; i < lim && m_emit == 0; i++) run(1, 1'b1, 100, 0);
    chk("timeout_emit", m_emit > 0, 1);
  endtask

  task automatic go_idle();
    run(2 * FL + HP, 1'b0, 0, 0);
    bus.pcm_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; quiet = 1'b1;
    bus.pcm_valid = 1'b0; bus.pcm_in = '0;
    bus.coef_wr_en = 1'b0; bus.coef_wr_addr = '0; bus.coef_wr_data = '0;
    foreach (coef[i]) coef[i] = 32767;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    run(10, 1'b0, 0, 0);
    quiet = 1'b0;

    // rectangular window, 1..12 at full rate: frames 1..8 then 5..12
    for (int i = 1; i <= 12; i++) src_q.push_back(i);
    run(40, 1'b1, 100, 0);
    go_idle();

    // half-scale window, rounding of positive and negative products
    for (int i = 0; i < FL; i++) cw_q.push_back('{i, 16'h4000});
    run(FL + 2, 1'b0, 0, 0);
    src_q = '{1000, -3, 1000, -3, 1000, -3, -32768, 32767};
    run(25, 1'b1, 100, 0);
    go_idle();

    // full-scale extremes, saturation on index FL-1
    for (int i = 0; i < FL - 1; i++) cw_q.push_back('{i, 16'h7FFF});
    cw_q.push_back('{FL - 1, 16'h8000});
    run(FL + 2, 1'b0, 0, 0);
    for (int i = 0; i < FL; i++) src_q.push_back(-32768);
    run(25, 1'b1, 100, 0);

    // dropped write during EMIT, then a HOP write to index 3
    wait_emit(40);
    cw_q.push_back('{3, 16'h1234});
    run(1, 1'b1, 100, 0);
    for (int i = 0; i < 40 && m_emit > 0; i++) run(1, 1'b1, 100, 0);
    cw_q.push_back('{3, 16'h2000});
    run(30, 1'b1, 100, 0);

    // disable two samples into HOP, then a full refill is needed
    wait_emit(40);
    for (int i = 0; i < 40 && m_emit > 0; i++) run(1, 1'b1, 100, 0);
    run(2, 1'b1, 100, 0);
    run(6, 1'b0, 0, 0);
    run(30, 1'b1, 70, 0);

    // reset in the middle of EMIT
    wait_emit(40);
    for (int i = 0; i < 40 && m_emit > 4; i++) run(1, 1'b1, 100, 0);
    rst = 1'b1;
    run(1, 1'b1, 100, 0);
    rst = 1'b0;
    run(30, 1'b1, 100, 0);

    for (int b = 0; b < 40; b++)
      run($urandom_range(5, 40), $urandom_range(99) < 85, $urandom_range(30, 100), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
